// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM encodings and width helper for the serial-path blocks.
//   ST_IDLE / ST_SHIFT : transmitter state encodings
//   bit_idx_w(width)   : width of a counter that indexes 0..width-1
package serial_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   function automatic int bit_idx_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter feeding a serial detector.
//   clk, rst        : clock, synchronous active-high reset
//   din, din_valid  : parallel word and its valid flag
//   din_ready       : word can be accepted this cycle (combinational)
//   w               : registered serial bit stream
//   busy, done      : frame bit on w / last frame bit on w (registered)
module serial_word_tx
   import serial_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             w,
   output logic             busy,
   output logic             done
);

   localparam int             CW   = bit_idx_w(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             w_q, w_d;
   logic             busy_q, done_q;
   logic             last, accept;
   logic             first_bit, next_bit;
   logic [WIDTH-1:0] sh_load, sh_next;

   // The shift register holds only the bits not yet driven on w, so the
   // outgoing bit always sits at the same end of the register.
   if (MSB_FIRST) begin : g_msb
      assign first_bit = din[WIDTH-1];
      assign sh_load   = {din[WIDTH-2:0], 1'b0};
      assign next_bit  = sh_q[WIDTH-1];
      assign sh_next   = {sh_q[WIDTH-2:0], 1'b0};
   end else begin : g_lsb
      assign first_bit = din[0];
      assign sh_load   = {1'b0, din[WIDTH-1:1]};
      assign next_bit  = sh_q[0];
      assign sh_next   = {1'b0, sh_q[WIDTH-1:1]};
   end

   assign last      = cnt_q == LAST;
   assign din_ready = !rst && (state_q == ST_IDLE || last);
   assign accept    = din_valid && din_ready;

   // An accepted word always restarts the frame, whether from IDLE or from
   // the last bit of the previous frame, so words stream with no gap bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      w_d     = w_q;
      if (accept) begin
         state_d = ST_SHIFT;
         cnt_d   = '0;
         sh_d    = sh_load;
         w_d     = first_bit;
      end else if (state_q == ST_SHIFT && !last) begin
         cnt_d = cnt_q + CW'(1);
         sh_d  = sh_next;
         w_d   = next_bit;
      end else begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         w_d     = IDLE_BIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         w_q     <= IDLE_BIT;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         w_q     <= w_d;
         busy_q  <= state_d == ST_SHIFT;
         done_q  <= state_d == ST_SHIFT && cnt_d == LAST;
      end
   end

   assign w    = w_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
